// File: rtl/avalon_mult_master.sv
// avalon_mult_master: Avalon-MM initiator for a memory-mapped multiplier slave.
// On a start strobe it writes operand A and operand B, then reads the product
// back and returns it with a one-cycle done pulse.
// Optional feature macro: AVM_MULT_SELFCHECK_EN. When defined, a local
// multiplier checks the returned product and sets a sticky mismatch flag.
module avalon_mult_master #(
    parameter int OP_W         = 4,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 2,
    parameter int ADDR_A       = 0,
    parameter int ADDR_B       = 1,
    parameter int ADDR_Z       = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iStart,
    input  logic [OP_W-1:0]   iOpA,
    input  logic [OP_W-1:0]   iOpB,
    output logic              oBusy,
    output logic              oDone,
    output logic [DATA_W-1:0] oResult,
    output logic              oMismatch,
    output logic              oChipSelect_n,
    output logic              oWrite_n,
    output logic              oRead_n,
    output logic [ADDR_W-1:0] oAddress,
    output logic [DATA_W-1:0] oData,
    input  logic [DATA_W-1:0] iData,
    input  logic              iWaitRequest
);

    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        WR_B,
        RD_REQ,
        RD_WAIT,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_A_W = ADDR_W'(ADDR_A);
    localparam logic [ADDR_W-1:0] ADDR_B_W = ADDR_W'(ADDR_B);
    localparam logic [ADDR_W-1:0] ADDR_Z_W = ADDR_W'(ADDR_Z);
    localparam bit                ZERO_LAT = (READ_LATENCY == 0);
    localparam logic [1:0]        LAT_LOAD = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

    state_t            state;
    logic [OP_W-1:0]   op_b;
    logic [1:0]        lat_cnt;
    logic              capture;

    // Read data is taken either in the accept cycle (zero latency) or when
    // the latency counter has run down to zero.
    assign capture = ((state == RD_REQ) && !iWaitRequest && ZERO_LAT) ||
                     ((state == RD_WAIT) && (lat_cnt == 2'd0));

    // Main sequencer: every bus and status output is a register here, so the
    // wait request never reaches an output combinationally.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state         <= IDLE;
            op_b          <= '0;
            lat_cnt       <= 2'd0;
            oChipSelect_n <= 1'b1;
            oWrite_n      <= 1'b1;
            oRead_n       <= 1'b1;
            oAddress      <= '0;
            oData         <= '0;
            oResult       <= '0;
            oBusy         <= 1'b0;
            oDone         <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        op_b          <= iOpB;
                        oBusy         <= 1'b1;
                        oChipSelect_n <= 1'b0;
                        oWrite_n      <= 1'b0;
                        oAddress      <= ADDR_A_W;
                        oData         <= {{(DATA_W-OP_W){1'b0}}, iOpA};
                        state         <= WR_A;
                    end
                end
                WR_A: begin
                    if (!iWaitRequest) begin
                        oAddress <= ADDR_B_W;
                        oData    <= {{(DATA_W-OP_W){1'b0}}, op_b};
                        state    <= WR_B;
                    end
                end
                WR_B: begin
                    if (!iWaitRequest) begin
                        oWrite_n <= 1'b1;
                        oRead_n  <= 1'b0;
                        oAddress <= ADDR_Z_W;
                        oData    <= '0;
                        state    <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (!iWaitRequest) begin
                        oChipSelect_n <= 1'b1;
                        oRead_n       <= 1'b1;
                        oAddress      <= '0;
                        if (!ZERO_LAT) begin
                            lat_cnt <= LAT_LOAD;
                            state   <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt != 2'd0) begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                DONE: begin
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (capture) begin
                oResult <= iData;
                oDone   <= 1'b1;
                state   <= DONE;
            end
        end
    end

`ifdef AVM_MULT_SELFCHECK_EN
    logic [DATA_W-1:0] expected;
    logic [2*OP_W-1:0] product;

    assign product = {{OP_W{1'b0}}, iOpA} * {{OP_W{1'b0}}, iOpB};

    // Remember the product at start and flag any later disagreement forever.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            expected  <= '0;
            oMismatch <= 1'b0;
        end else begin
            if ((state == IDLE) && iStart) begin
                expected <= DATA_W'(product);
            end
            if (capture && (iData != expected)) begin
                oMismatch <= 1'b1;
            end
        end
    end
`else
    assign oMismatch = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_mult_master.sv
// tb_avalon_mult_master: drives three copies of the initiator (read latency
// 1, 0 and 3) against behavioural multiplier slaves and checks bus traffic,
// timing and results against a transaction-level reference.
module tb_avalon_mult_master;

    localparam int NDUT = 3;
    localparam int LATS [NDUT] = '{1, 0, 3};

    logic        clock = 1'b0;
    logic        reset;
    logic        waitReq;
    logic [3:0]  opA;
    logic [3:0]  opB;
    logic        corrupt;
    logic        start   [NDUT];
    logic        busy    [NDUT];
    logic        done    [NDUT];
    logic        mis     [NDUT];
    logic        csN     [NDUT];
    logic        wrN     [NDUT];
    logic        rdN     [NDUT];
    logic [1:0]  addr    [NDUT];
    logic [31:0] wdata   [NDUT];
    logic [31:0] rdata   [NDUT];
    logic [31:0] result  [NDUT];

    int compared   = 0;
    int mismatched = 0;
    bit misExp     = 1'b0;

    // Free-running 10-unit clock.
    always #5 clock = ~clock;

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        logic [31:0] regA;
        logic [31:0] regB;
        logic [31:0] zVal;
        int          left;

        avalon_mult_master #(.READ_LATENCY(LATS[g])) dut (
            .iClk          (clock),
            .iReset        (reset),
            .iStart        (start[g]),
            .iOpA          (opA),
            .iOpB          (opB),
            .oBusy         (busy[g]),
            .oDone         (done[g]),
            .oResult       (result[g]),
            .oMismatch     (mis[g]),
            .oChipSelect_n (csN[g]),
            .oWrite_n      (wrN[g]),
            .oRead_n       (rdN[g]),
            .oAddress      (addr[g]),
            .oData         (wdata[g]),
            .iData         (rdata[g]),
            .iWaitRequest  (waitReq)
        );

        assign zVal = corrupt ? 32'd20 : regA * regB;

        if (LATS[g] == 0) begin : gComb
            assign rdata[g] = (!csN[g] && !rdN[g] && !waitReq) ? zVal : 32'hDEADBEEF;
        end else begin : gPipe
            assign rdata[g] = (left == 1) ? zVal : 32'hDEADBEEF;
        end

        // Slave model: stores accepted operand writes and presents the
        // product a fixed number of cycles after an accepted read.
        always @(posedge clock or posedge reset) begin
            if (reset) begin
                regA <= 32'd0;
                regB <= 32'd0;
                left <= 0;
            end else if (!csN[g] && !waitReq) begin
                if (!wrN[g] && addr[g] == 2'd0) regA <= wdata[g];
                if (!wrN[g] && addr[g] == 2'd1) regB <= wdata[g];
                if (!rdN[g]) left <= LATS[g];
            end else if (left > 0) begin
                left <= left - 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            checkOutput({tag, "_bus"}, {csN[k], wrN[k], rdN[k], addr[k], wdata[k]},
                        {1'b1, 1'b1, 1'b1, 2'd0, 32'd0});
            checkOutput({tag, "_status"}, {result[k], busy[k], done[k], mis[k]},
                        {32'd0, 1'b0, 1'b0, 1'b0});
        end
    endtask

    // One multiply on all three instances with the given wait-state counts on
    // A write, B write and read request; optionally pulses extra starts while
    // busy, which must be ignored.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 input int stA, input int stB, input int stR,
                                 input bit pulseExtra);
        int          expDone [NDUT];
        int          last;
        int          remA;
        int          remB;
        int          remR;
        logic [31:0] expRes;
        logic [34:0] expXfer [3];
        logic [34:0] seen [$];
        logic [36:0] curBus;
        logic [36:0] prevBus;
        bit          prevStall;

        remA = stA;
        remB = stB;
        remR = stR;
        prevStall = 1'b0;
        prevBus = '0;
        expRes = corrupt ? 32'd20 : 32'(a) * 32'(b);
`ifdef AVM_MULT_SELFCHECK_EN
        if (expRes != 32'(a) * 32'(b)) misExp = 1'b1;
`endif
        expXfer[0] = {1'b1, 2'd0, 28'd0, a};
        expXfer[1] = {1'b1, 2'd1, 28'd0, b};
        expXfer[2] = {1'b0, 2'd2, 32'd0};
        last = 0;
        for (int k = 0; k < NDUT; k++) begin
            expDone[k] = 4 + LATS[k] + stA + stB + stR;
            if (expDone[k] > last) last = expDone[k];
        end

        opA = a;
        opB = b;
        for (int k = 0; k < NDUT; k++) start[k] = 1'b1;
        @(posedge clock); #1;
        for (int k = 0; k < NDUT; k++) start[k] = 1'b0;

        for (int cyc = 1; cyc <= last + 2; cyc++) begin
            opA = 4'($urandom);
            opB = 4'($urandom);
            curBus = {csN[0], wrN[0], rdN[0], addr[0], wdata[0]};
            waitReq = 1'b0;
            if (!csN[0] && !wrN[0] && addr[0] == 2'd0 && remA > 0) begin
                waitReq = 1'b1;
                remA--;
            end
            if (!csN[0] && !wrN[0] && addr[0] == 2'd1 && remB > 0) begin
                waitReq = 1'b1;
                remB--;
            end
            if (!csN[0] && !rdN[0] && addr[0] == 2'd2 && remR > 0) begin
                waitReq = 1'b1;
                remR--;
            end
            if (prevStall) checkOutput("stall_hold", curBus, prevBus);
            if (!csN[0] && !waitReq) seen.push_back({!wrN[0], addr[0], wdata[0]});
            if (csN[0]) checkOutput("idle_bus", {wrN[0], rdN[0], wdata[0]}, {1'b1, 1'b1, 32'd0});
            prevStall = waitReq;
            prevBus = curBus;
            for (int k = 0; k < NDUT; k++) begin
                checkOutput($sformatf("busy_l%0d", LATS[k]), busy[k], cyc <= expDone[k]);
                checkOutput($sformatf("done_l%0d", LATS[k]), done[k], cyc == expDone[k]);
                if (cyc == expDone[k]) begin
                    checkOutput($sformatf("result_l%0d", LATS[k]), result[k], expRes);
                    checkOutput($sformatf("mismatch_l%0d", LATS[k]), mis[k], misExp);
                end
            end
            if (pulseExtra) begin
                if (!csN[0] && !wrN[0] && addr[0] == 2'd1) begin
                    for (int k = 0; k < NDUT; k++) start[k] = 1'b1;
                end
                for (int k = 0; k < NDUT; k++) begin
                    if (done[k]) start[k] = 1'b1;
                end
            end
            @(posedge clock); #1;
            for (int k = 0; k < NDUT; k++) start[k] = 1'b0;
        end
        waitReq = 1'b0;

        checkOutput("xfer_count", seen.size(), 3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("xfer_%0d", i), (i < seen.size()) ? seen[i] : '1, expXfer[i]);
        end
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("result_hold_l%0d", LATS[k]), result[k], expRes);
            checkOutput($sformatf("mismatch_hold_l%0d", LATS[k]), mis[k], misExp);
        end
    endtask

    initial begin
        reset = 1'b1;
        waitReq = 1'b0;
        corrupt = 1'b0;
        opA = 4'd0;
        opB = 4'd0;
        for (int k = 0; k < NDUT; k++) start[k] = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkReset("reset_state");
        reset = 1'b0;
        @(posedge clock); #1;

        // Reset in the middle of a stalled B write.
        opA = 4'd6;
        opB = 4'd9;
        for (int k = 0; k < NDUT; k++) start[k] = 1'b1;
        @(posedge clock); #1;
        for (int k = 0; k < NDUT; k++) start[k] = 1'b0;
        checkOutput("wra_bus", {csN[0], wrN[0], addr[0], wdata[0]}, {1'b0, 1'b0, 2'd0, 32'd6});
        @(posedge clock); #1;
        waitReq = 1'b1;
        @(posedge clock); #1;
        checkOutput("wrb_stalled", {csN[0], wrN[0], addr[0], wdata[0]}, {1'b0, 1'b0, 2'd1, 32'd9});
        #3;
        reset = 1'b1;
        #1;
        checkReset("async_reset");
        misExp = 1'b0;
        @(posedge clock); #1;
        waitReq = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;

        applyStimulus(4'd3, 4'd5, 0, 0, 0, 1'b0);
        applyStimulus(4'd15, 4'd15, 3, 0, 3, 1'b0);
        applyStimulus(4'd7, 4'd9, 0, 0, 0, 1'b1);
        for (int n = 0; n < 8; n++) begin
            applyStimulus(4'($urandom), 4'($urandom), int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                          1'($urandom_range(0, 1)));
        end

        corrupt = 1'b1;
        applyStimulus(4'd4, 4'd4, 0, 0, 0, 1'b0);
        corrupt = 1'b0;
        applyStimulus(4'd2, 4'd3, 0, 1, 0, 1'b0);
        applyStimulus(4'($urandom), 4'($urandom), 1, 0, 1, 1'b1);

        reset = 1'b1;
        misExp = 1'b0;
        @(posedge clock); #1;
        checkReset("reset_clear");
        reset = 1'b0;
        @(posedge clock); #1;
        applyStimulus(4'd5, 4'd6, 1, 1, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
